// File: rtl/riscv_v_elastic_stage.sv
// riscv_v_elastic_stage
// Depth-configurable elastic pipeline with one valid bit per slot. It sits
// between vector decode, issue and execute, where downstream lanes can stall.
// An empty slot always accepts from its predecessor, so bubbles collapse even
// while the output is stalled.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   en                  global enable; 0 freezes every slot
//   flush               synchronous kill of all in-flight entries
//   in_valid/in_ready   upstream handshake; in_data is the upstream payload
//   out_valid/out_ready downstream handshake; out_data is the last slot
//                       register and is driven even when invalid
//   stage_valid         per-slot valid bits, bit 0 = input slot
//   occupancy           number of occupied slots
module riscv_v_elastic_stage #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        NUM_STAGES = 2,
  parameter logic [DATA_W-1:0]  RST_VAL    = '0,
  parameter logic [DATA_W-1:0]  FLUSH_VAL  = '0,
  localparam int unsigned       OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]      occupancy
);

  logic [NUM_STAGES-1:0] v;
  logic [DATA_W-1:0]     d [NUM_STAGES];

  logic [NUM_STAGES-1:0] acc;
  logic [NUM_STAGES-1:0] src_v;
  logic [DATA_W-1:0]     src_d [NUM_STAGES];
  logic [OCC_W-1:0]      occ_c;

  // Slot i can accept when any slot from i to the output is empty, or the
  // output is draining. Written as a reduction rather than a ripple chain so
  // the accept terms do not feed back on one another.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_acc
    assign acc[g] = out_ready | ~(&v[NUM_STAGES-1:g]);
  end

  // Each slot's source is its predecessor; slot 0 is fed from upstream.
  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < NUM_STAGES; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < NUM_STAGES; i++) d[i] <= RST_VAL;
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < NUM_STAGES; i++) d[i] <= FLUSH_VAL;
    end else if (en) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (acc[i]) begin
          v[i] <= src_v[i];
          // Data only moves with a valid entry; a bubble leaves it untouched.
          if (src_v[i]) d[i] <= src_d[i];
        end
      end
    end
  end

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < NUM_STAGES; i++) occ_c = occ_c + OCC_W'(v[i]);
  end

  assign in_ready    = en & ~flush & acc[0];
  // Not gated by flush: a consumer must ignore out_valid in a flush cycle.
  assign out_valid   = en & v[NUM_STAGES-1];
  assign out_data    = d[NUM_STAGES-1];
  assign stage_valid = v;
  assign occupancy   = occ_c;

endmodule

// File: tb/tb_riscv_v_elastic_stage.sv
// Testbench for riscv_v_elastic_stage (DATA_W=8, NUM_STAGES=3).
// A slot-level reference model plus an in-order scoreboard predict every
// output each cycle; directed scenarios add explicit expectations.
module tb_riscv_v_elastic_stage;

  localparam int NS = 3;
  localparam int DW = 8;
  localparam int OW = $clog2(NS + 1);
  localparam logic [DW-1:0] RST_V   = 8'h5A;
  localparam logic [DW-1:0] FLUSH_V = 8'hC3;

  logic          clk, rst, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [NS-1:0] stage_valid;
  logic [OW-1:0] occupancy;

  riscv_v_elastic_stage #(
    .DATA_W(DW), .NUM_STAGES(NS), .RST_VAL(RST_V), .FLUSH_VAL(FLUSH_V)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stage_valid(stage_valid), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream must hold a rejected request unchanged (flush cycles excepted).
  property p_hold;
    @(posedge clk) disable iff (rst)
      (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data));
  endproperty
  a_hold: assert property (p_hold) else $error("upstream dropped a pending request");

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-slot occupancy/contents and expected output order.
  logic [NS-1:0] mv;
  logic [DW-1:0] md [NS];
  logic [DW-1:0] sb [$];
  logic          took;

  task automatic model_reset();
    mv = '0;
    for (int i = 0; i < NS; i++) md[i] = RST_V;
    sb.delete();
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  // Returns at posedge+1 with the model holding the new state.
  task automatic step();
    logic [NS-1:0] nv;
    logic [DW-1:0] nd [NS];
    logic          exp_ir, exp_ov;
    @(negedge clk);
    exp_ir = en && !flush && (($countones(mv) < NS) || out_ready);
    exp_ov = en && mv[NS-1];
    check_val("in_ready", in_ready, exp_ir);
    check_val("out_valid", out_valid, exp_ov);
    check_val("stage_valid", stage_valid, mv);
    check_val("occupancy", occupancy, $countones(mv));
    check_val("out_data", out_data, md[NS-1]);
    took = in_valid && exp_ir;
    nv = mv;
    nd = md;
    if (flush) begin
      nv = '0;
      for (int i = 0; i < NS; i++) nd[i] = FLUSH_V;
      sb.delete();
    end else if (en) begin
      if (mv[NS-1] && out_ready) begin
        if (sb.size() > 0) check_val("order", out_data, sb.pop_front());
        else check_val("underflow", sb.size(), 1);
        nv[NS-1] = 1'b0;
      end
      // Items advance one slot into any space that opened downstream.
      for (int i = NS - 1; i >= 1; i--) begin
        if (!nv[i] && mv[i-1]) begin
          nv[i]   = 1'b1;
          nd[i]   = md[i-1];
          nv[i-1] = 1'b0;
        end
      end
      if (took) begin
        nv[0] = 1'b1;
        nd[0] = in_data;
        sb.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
    mv = nv;
    md = nd;
  endtask

  task automatic fill(input logic [DW-1:0] base, input int n);
    int got;
    got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 2 * n + 2 && got < n; c++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(got);
      step();
      if (took) got++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < NS + 1; c++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [DW-1:0] nxt;

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_stage_valid", stage_valid, 0);
    check_val("rst_occupancy", occupancy, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, RST_V);
    check_val("rst_in_ready", in_ready, 1);
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Latency: one item through an empty pipe
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check_val("lat_occ", occupancy, (k <= 3) ? 1 : 0);
      check_val("lat_out_valid", out_valid, (k == 3) ? 1 : 0);
      if (k == 3) check_val("lat_out_data", out_data, 8'hA5);
      step();
    end

    // Backpressure fill then release
    out_ready = 1'b0; nxt = 8'h01;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = nxt;
      #1;
      check_val("bp_in_ready", in_ready, (c < 3) ? 1 : 0);
      step();
      if (took) nxt++;
    end
    check_val("bp_occ", occupancy, 3);
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (nxt <= 8'h05) begin in_valid = 1'b1; in_data = nxt; end
      else in_valid = 1'b0;
      #1;
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_out_data", out_data, r + 1);
      step();
      if (took) nxt++;
    end
    in_valid = 1'b0;
    drain();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'h22; step();
    in_valid = 1'b0; step();
    #1;
    check_val("bub_stage_valid", stage_valid, 3'b110);
    check_val("bub_out_data", out_data, 8'h11);
    step();
    check_val("bub_hold", stage_valid, 3'b110);
    out_ready = 1'b1;
    #1;
    check_val("bub_first", out_data, 8'h11);
    step();
    check_val("bub_second_v", out_valid, 1);
    check_val("bub_second", out_data, 8'h22);
    step();
    check_val("bub_empty", out_valid, 0);

    // Flush with a full pipe and a competing push
    fill(8'h41, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check_val("fl_in_ready", in_ready, 0);
    check_val("fl_out_valid", out_valid, 1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_val("fl_stage_valid", stage_valid, 0);
    check_val("fl_out_data", out_data, FLUSH_V);
    check_val("fl_occ", occupancy, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_val("fl_no_out", out_valid, 0);
      step();
    end

    // Enable freeze on a full pipe
    fill(8'h31, 3);
    out_ready = 1'b1; en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_val("en_out_valid", out_valid, 0);
      check_val("en_in_ready", in_ready, 0);
      check_val("en_stage_valid", stage_valid, 3'b111);
      check_val("en_out_data", out_data, 8'h31);
      step();
    end
    en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      #1;
      check_val("en_resume_v", out_valid, 1);
      check_val("en_resume_d", out_data, 8'h31 + r);
      step();
    end
    drain();

    // Asynchronous reset between edges with two entries in flight
    fill(8'h61, 2);
    #2 rst = 1'b1;
    #1;
    check_val("ar_stage_valid", stage_valid, 0);
    check_val("ar_out_data", out_data, RST_V);
    check_val("ar_occ", occupancy, 0);
    model_reset();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_val("ar_no_out", out_valid, 0);
      step();
    end

    // Randomised traffic with enable, flush and backpressure
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
      end
      step();
      if (took || flush) in_valid = 1'b0;
    end
    flush = 1'b0;
    drain();
    check_val("final_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_v_elastic_stage.md
Name: riscv_v_elastic_stage

Overview:
- Parametrised successor to the fixed en/flush delay stage.
- Depth-configurable pipeline of NUM_STAGES registered slots, each with its own valid bit.
- valid/ready handshake on both ends; backpressure propagates per stage; bubbles collapse.
- Used between vector decode, issue and execute, where downstream lanes can stall.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- NUM_STAGES, 2, number of register slots (>=1).
- RST_VAL, 0, DATA_W value loaded into every slot data register on reset.
- FLUSH_VAL, 0, DATA_W value loaded into every slot data register on flush.
- OCC_W, $clog2(NUM_STAGES+1), width of the occupancy output (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; 0 freezes all slots.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  last slot holds valid data and en=1.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  last slot data register (driven even when invalid).
- stage_valid  output  NUM_STAGES  valid bit per slot; bit 0 = input slot.
- occupancy  output  OCC_W  number of set stage_valid bits.

Behaviour:
- Reset (asynchronous): all valid bits 0 and all data registers = RST_VAL. Consequently out_valid=0, occupancy=0, out_data=RST_VAL, stage_valid=0. in_ready follows its equation (1 when en=1 and flush=0).
- Slot state: v[i] and d[i] for i = 0..NUM_STAGES-1.
- Accept chain (combinational, en=1, flush=0):
  - acc[N-1] = ~v[N-1] | out_ready.
  - acc[i] = ~v[i] | acc[i+1].
  - in_ready = en & ~flush & acc[0].
  - out_valid = en & v[N-1].
- Per-slot update when en=1, flush=0 and acc[i]=1:
  - v[i] <= previous-slot valid (in_valid for slot 0); d[i] <= previous-slot data.
  - d[i] loads only when the incoming valid is 1; otherwise d[i] holds.
- A slot with acc[i]=0 holds v and d.
- Bubble collapse: an empty slot accepts from its predecessor even while downstream stalls.
- Latency: an item entering an empty pipe with out_ready=1 appears on out_data/out_valid exactly NUM_STAGES cycles after the in_valid&in_ready cycle.
- Throughput: 1 item/cycle when out_ready is held at 1.
- Full: all v=1 and out_ready=0 -> in_ready=0 and nothing moves. Data is never dropped or duplicated.
- Simultaneous pop and push when full with out_ready=1: every slot shifts, in_ready=1, occupancy unchanged.
- Flush (sync, priority over en and handshakes):
  - Next edge: all v<=0 and all d<=FLUSH_VAL.
  - in_ready=0 during the flush cycle; in_data presented that cycle is discarded.
  - out_valid still reflects en & v[N-1] that cycle. Downstream must ignore it; this is documented, not gated.
- en=0: no slot updates; in_ready=0; out_valid=0. stage_valid and occupancy still show the held state. Flush still acts.
- Reset mid-operation: asynchronous clear regardless of en, flush or handshakes; all entries are lost.
- occupancy is a combinational popcount of v.
- NUM_STAGES=1: a single-slot elastic register with acc[0] = ~v[0] | out_ready.
- in_valid is ignored when in_ready=0. Upstream must hold in_valid and in_data until accepted, by protocol; the bench asserts this.

Test Plan:
- Latency: NUM_STAGES=3, DATA_W=8, out_ready=1, push 0xA5 once -> out_valid high exactly 3 cycles later with out_data=0xA5; occupancy goes 1,1,1,0.
- Backpressure fill: NUM_STAGES=3, out_ready=0, push 0x01..0x05 continuously -> 0x01..0x03 accepted, in_ready=0 from cycle 3, occupancy=3. Release out_ready -> outputs 0x01,0x02,0x03 back-to-back with no loss.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, out_ready=0 -> after 4 cycles stage_valid=3'b110 and both are held. Raise out_ready -> 0x11 then 0x22 on consecutive cycles.
- Flush: pipe holds 3 entries, flush=1 with in_valid=1, in_data=0x77 -> next cycle stage_valid=0, out_data=FLUSH_VAL, 0x77 never appears at the output.
- Enable freeze: full pipe, out_ready=1, en=0 for 2 cycles -> out_valid=0, in_ready=0, contents unchanged. en=1 -> original order resumes.
- Async reset mid-stream: rst pulsed between clock edges while 2 entries are in flight -> immediately stage_valid=0, out_data=RST_VAL, occupancy=0, no outputs after release.
